cmn_burst_rr_arb: RTL



---
 rtl/cmn_burst_rr_arb.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cmn_burst_rr_arb.sv
// Round-robin burst arbiter/mux: shares one val/rdy stream among p_num_reqs bursting requesters.
// Define CMN_BURST_RR_ARB_OUTREG_EN to add a one-entry output pipe register (latency 1).
module cmn_burst_rr_arb #(
    parameter int p_num_reqs  = 4,
    parameter int p_msg_nbits = 32,
    parameter int p_src_nbits = $clog2(p_num_reqs)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [p_num_reqs-1:0]             in_val,
    output logic [p_num_reqs-1:0]             in_rdy,
    input  logic [p_num_reqs*p_msg_nbits-1:0] in_msg,
    input  logic [p_num_reqs-1:0]             in_last,
    output logic                              out_val,
    input  logic                              out_rdy,
    output logic [p_msg_nbits-1:0]            out_msg,
    output logic                              out_last,
    output logic [p_src_nbits-1:0]            out_src
);

    localparam int N = p_num_reqs;
    localparam int W = p_msg_nbits;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_e;

    lock_e                  state_q;
    logic [N-1:0]           grant_q;
    logic [N-1:0]           prio_q;

    logic [N-1:0]           rr_grant;
    logic [N-1:0]           grant;
    logic                   mux_val;
    logic [W-1:0]           mux_msg;
    logic                   mux_last;
    logic [p_src_nbits-1:0] mux_src;
    logic                   up_rdy;
    logic                   up_fire;

    function automatic logic [p_src_nbits-1:0] onehot_to_idx(input logic [N-1:0] oh);
        logic [p_src_nbits-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) idx = idx | p_src_nbits'(i);
        end
        return idx;
    endfunction

    // Rotate requests so the priority bit lands at index 0, take the first set bit, rotate back.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req, input logic [N-1:0] prio);
        logic [p_src_nbits-1:0] start;
        logic [2*N-1:0]         dbl;
        logic [N-1:0]           rot;
        logic [N-1:0]           pick_rot;
        logic                   found;
        start    = onehot_to_idx(prio);
        dbl      = {req, req} >> start;
        rot      = dbl[N-1:0];
        pick_rot = '0;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                pick_rot[i] = 1'b1;
                found       = 1'b1;
            end
        end
        dbl = {pick_rot, pick_rot} << start;
        return dbl[2*N-1:N];
    endfunction

    always_comb begin
        rr_grant = rr_pick(in_val, prio_q);
        grant    = (state_q == ST_LOCKED) ? grant_q : rr_grant;
    end

    always_comb begin
        mux_val  = |(in_val & grant);
        mux_msg  = '0;
        mux_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                mux_msg  = in_msg[i*W +: W];
                mux_last = in_last[i];
            end
        end
        mux_src = onehot_to_idx(grant);
    end

`ifdef CMN_BURST_RR_ARB_OUTREG_EN
    logic                   pv_q,    pv_d;
    logic [W-1:0]           pmsg_q,  pmsg_d;
    logic                   plast_q, plast_d;
    logic [p_src_nbits-1:0] psrc_q,  psrc_d;

    assign up_rdy = out_rdy | ~pv_q;

    always_comb begin
        pv_d    = pv_q;
        pmsg_d  = pmsg_q;
        plast_d = plast_q;
        psrc_d  = psrc_q;
        if (up_rdy) begin
            pv_d    = mux_val;
            pmsg_d  = mux_msg;
            plast_d = mux_last;
            psrc_d  = mux_src;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv_q    <= 1'b0;
            pmsg_q  <= '0;
            plast_q <= 1'b0;
            psrc_q  <= '0;
        end else begin
            pv_q    <= pv_d;
            pmsg_q  <= pmsg_d;
            plast_q <= plast_d;
            psrc_q  <= psrc_d;
        end
    end

    assign out_val  = pv_q;
    assign out_msg  = pmsg_q;
    assign out_last = plast_q;
    assign out_src  = psrc_q;
`else
    assign up_rdy   = out_rdy;
    assign out_val  = mux_val;
    assign out_msg  = mux_msg;
    assign out_last = mux_last;
    assign out_src  = mux_src;
`endif

    assign in_rdy  = grant & {N{up_rdy}};
    assign up_fire = mux_val & up_rdy;

    // Lock holds a granted burst (or a stalled beat) until its last beat is accepted upstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_UNLOCKED;
            grant_q <= '0;
            prio_q  <= {{(N-1){1'b0}}, 1'b1};
        end else if (up_fire && mux_last) begin
            state_q <= ST_UNLOCKED;
            prio_q  <= {grant[N-2:0], grant[N-1]};
        end else if (|grant) begin
            state_q <= ST_LOCKED;
            grant_q <= grant;
        end
    end

endmodule
